mux_rr_n: RTL and testbench

- N-input, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output.
- Arbitration is round-robin or fixed-priority, set by parameter.
- Optional packet lock: a channel that wins keeps the grant until its last beat.
- The output is registered. The block sits between multiple producers (e.g. fetch/LSU request ports) and a single shared consumer.

---
 rtl/mux_rr_n_pkg.sv | 13 +
 rtl/mux_rr_n_if.sv | 27 ++
 rtl/mux_rr_n_arbiter.sv | 47 ++++
 rtl/mux_rr_n_chk.sv | 23 ++
 rtl/mux_rr_n.sv | 133 +++++++++++++
 tb/tb_mux_rr_n.sv | 360 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mux_rr_n_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority N-input mux.
package mux_rr_pkg;

    typedef enum logic [0:0] {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_n_if.sv
// Handshake bundle between the producers, the mux and the shared consumer.
interface mux_rr_n_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SELW = mux_rr_pkg::sel_width(NUM_IN);

    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_last;
    logic [SELW-1:0]         out_sel;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/mux_rr_n_arbiter.sv
// Combinational grant selection: lock override, else masked double-width priority encode.
module rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int RR_MODE = 1,
    localparam int SELW   = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [SELW-1:0]   ptr_i,
    input  logic              lock_i,
    input  logic [SELW-1:0]   lock_ch_i,
    output logic [NUM_IN-1:0] grant_o,
    output logic [SELW-1:0]   grant_idx_o,
    output logic              grant_valid_o
);

    logic [2*NUM_IN-1:0] mask_s;
    logic [2*NUM_IN-1:0] dbl_s;
    logic [SELW:0]       hit_s;
    logic [SELW:0]       wrap_s;
    logic [SELW-1:0]     base_s;

    // Lower copy keeps requests at or above the pointer, upper copy supplies the wrap-around.
    always_comb begin
        base_s = (RR_MODE != 0) ? ptr_i : {SELW{1'b0}};
        for (int j = 0; j < 2*NUM_IN; j++) begin
            mask_s[j] = (j >= NUM_IN) || (j >= int'(base_s));
        end
        dbl_s = {req_i, req_i} & mask_s;
        hit_s = {(SELW+1){1'b0}};
        for (int j = 2*NUM_IN-1; j >= 0; j--) begin
            hit_s = dbl_s[j] ? (SELW+1)'(j) : hit_s;
        end
        wrap_s = hit_s - (SELW+1)'(NUM_IN);
        if (lock_i) begin
            grant_idx_o   = lock_ch_i;
            grant_valid_o = 1'b1;
        end else begin
            grant_idx_o   = (hit_s >= (SELW+1)'(NUM_IN)) ? wrap_s[SELW-1:0] : hit_s[SELW-1:0];
            grant_valid_o = |req_i;
        end
        grant_o              = {NUM_IN{1'b0}};
        grant_o[grant_idx_o] = grant_valid_o;
    end

endmodule

// File: rtl/mux_rr_n_chk.sv
// Simulation-only protocol checks on the producer and consumer sides of the mux.
module mux_rr_n_chk #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input logic  clk,
    input logic  rst,
    mux_rr_n_if  bus
);

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        a_in_hold: assert property (@(posedge clk) disable iff (rst)
            bus.in_valid[i] && !bus.in_ready[i] |=>
                bus.in_valid[i] && $stable(bus.in_data[i*WIDTH +: WIDTH]) && $stable(bus.in_last[i]));
    end

    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data));

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.in_ready));

endmodule

// File: rtl/mux_rr_n.sv
// N-input valid/ready mux with registered output, round-robin pointer and optional packet lock.
module mux_rr_n
    import mux_rr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_IN   = 4,
    parameter int RR_MODE  = 1,
    parameter int PKT_LOCK = 0,
    localparam int SELW    = sel_width(NUM_IN)
) (
    input logic         clk,
    input logic         rst,
    mux_rr_n_if.slave   bus
);

    logic [NUM_IN-1:0] grant_s;
    logic [SELW-1:0]   grant_idx_s;
    logic              grant_valid_s;
    logic              free_s;
    logic              load_s;
    logic              last_g_s;
    logic [NUM_IN-1:0] in_ready_s;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic [SELW-1:0]   out_sel_q,   out_sel_d;
    logic [SELW-1:0]   ptr_q,       ptr_d;
    lock_state_e       lk_state_q,  lk_state_d;
    logic [SELW-1:0]   lock_ch_q,   lock_ch_d;

    rr_arbiter #(
        .NUM_IN  (NUM_IN),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .req_i         (bus.in_valid),
        .ptr_i         (ptr_q),
        .lock_i        (lk_state_q == LK_LOCKED),
        .lock_ch_i     (lock_ch_q),
        .grant_o       (grant_s),
        .grant_idx_o   (grant_idx_s),
        .grant_valid_o (grant_valid_s)
    );

    assign free_s   = !out_valid_q || bus.out_ready;
    assign last_g_s = bus.in_last[grant_idx_s];
    assign load_s   = grant_valid_s && bus.in_valid[grant_idx_s] && free_s;

    // Next-state for the output register, rotation pointer and lock FSM.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        lk_state_d  = lk_state_q;
        lock_ch_d   = lock_ch_q;
        in_ready_s  = {NUM_IN{1'b0}};

        if (free_s && grant_valid_s) begin
            in_ready_s = grant_s;
        end else begin
            in_ready_s = {NUM_IN{1'b0}};
        end

        if (load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[grant_idx_s*WIDTH +: WIDTH];
            out_last_d  = last_g_s && (PKT_LOCK != 0);
            out_sel_d   = grant_idx_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // With packet lock the rotation only advances once a packet closes.
        if ((RR_MODE != 0) && load_s && ((PKT_LOCK == 0) || last_g_s)) begin
            ptr_d = (grant_idx_s == SELW'(NUM_IN - 1)) ? {SELW{1'b0}} : grant_idx_s + SELW'(1'b1);
        end else begin
            ptr_d = ptr_q;
        end

        case (lk_state_q)
            LK_IDLE: begin
                if ((PKT_LOCK != 0) && load_s && !last_g_s) begin
                    lk_state_d = LK_LOCKED;
                    lock_ch_d  = grant_idx_s;
                end else begin
                    lk_state_d = LK_IDLE;
                end
            end
            LK_LOCKED: begin
                if (load_s && last_g_s) begin
                    lk_state_d = LK_IDLE;
                end else begin
                    lk_state_d = LK_LOCKED;
                end
            end
            default: begin
                lk_state_d = LK_IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight beat and any held lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_last_q  <= 1'b0;
            out_sel_q   <= {SELW{1'b0}};
            ptr_q       <= {SELW{1'b0}};
            lk_state_q  <= LK_IDLE;
            lock_ch_q   <= {SELW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
            lk_state_q  <= lk_state_d;
            lock_ch_q   <= lock_ch_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: three instances (RR, fixed priority, RR + packet lock) against a per-instance reference model.
module tb_mux_rr_n;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] vld  [NI];
    logic [N-1:0] lst  [NI];
    logic [W-1:0] dat  [NI][N];
    logic         ordy [NI];

    logic [N-1:0] rdy_w [NI];
    logic         ov_w  [NI];
    logic [W-1:0] od_w  [NI];
    logic         ol_w  [NI];
    logic [1:0]   os_w  [NI];

    int vectors = 0;
    int miscompares = 0;

    // Reference state: what the spec says each instance must hold.
    int           m_ptr    [NI];
    bit           m_locked [NI];
    int           m_lch    [NI];
    bit           m_ov     [NI];
    logic [W-1:0] m_od     [NI];
    bit           m_ol     [NI];
    int           m_os     [NI];
    logic [N-1:0] hs       [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        mux_rr_n_if #(.WIDTH(W), .NUM_IN(N)) bus ();
        assign bus.in_valid  = vld[g];
        assign bus.in_last   = lst[g];
        assign bus.in_data   = {dat[g][3], dat[g][2], dat[g][1], dat[g][0]};
        assign bus.out_ready = ordy[g];
        assign rdy_w[g] = bus.in_ready;
        assign ov_w[g]  = bus.out_valid;
        assign od_w[g]  = bus.out_data;
        assign ol_w[g]  = bus.out_last;
        assign os_w[g]  = bus.out_sel;

        mux_rr_n #(
            .WIDTH(W), .NUM_IN(N),
            .RR_MODE((g == 1) ? 0 : 1),
            .PKT_LOCK((g == 2) ? 1 : 0)
        ) u_dut (.clk(clk), .rst(rst), .bus(bus));

        mux_rr_n_chk #(.WIDTH(W), .NUM_IN(N)) u_chk (.clk(clk), .rst(rst), .bus(bus));
    end

    function automatic bit is_rr(int m);
        return m != 1;
    endfunction

    function automatic bit is_pl(int m);
        return m == 2;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NI; m++) begin
            m_ptr[m] = 0; m_locked[m] = 0; m_lch[m] = 0;
            m_ov[m] = 0; m_od[m] = '0; m_ol[m] = 0; m_os[m] = 0; hs[m] = '0;
        end
    endtask

    task automatic set_all(logic [N-1:0] v, logic [N-1:0] l, logic r);
        for (int m = 0; m < NI; m++) begin
            vld[m] = v; lst[m] = l; ordy[m] = r;
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic step();
        int g [NI];
        bit gv [NI];
        bit ld [NI];
        bit free;
        logic [N-1:0] er;
        #1;
        for (int m = 0; m < NI; m++) begin
            gv[m] = 0; g[m] = 0;
            if (m_locked[m]) begin
                g[m] = m_lch[m]; gv[m] = 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = is_rr(m) ? (m_ptr[m] + k) % N : k;
                    if (!gv[m] && vld[m][c]) begin g[m] = c; gv[m] = 1; end
                end
            end
            free = !m_ov[m] || ordy[m];
            er = (free && gv[m]) ? (4'b0001 << g[m]) : 4'b0000;
            vectors++;
            if (rdy_w[m] !== er) begin
                miscompares++;
                $display("FAIL in_ready inst%0d: got %b expected %b", m, rdy_w[m], er);
            end
            ld[m] = free && gv[m] && vld[m][g[m]];
            hs[m] = ld[m] ? (4'b0001 << g[m]) : 4'b0000;
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < NI; m++) begin
            if (ld[m]) begin
                m_ov[m] = 1; m_od[m] = dat[m][g[m]];
                m_ol[m] = lst[m][g[m]] && is_pl(m); m_os[m] = g[m];
                if (is_rr(m) && (!is_pl(m) || lst[m][g[m]])) m_ptr[m] = (g[m] + 1) % N;
                if (is_pl(m)) begin
                    if (!m_locked[m] && !lst[m][g[m]]) begin m_locked[m] = 1; m_lch[m] = g[m]; end
                    else if (m_locked[m] && lst[m][g[m]]) m_locked[m] = 0;
                end
            end else if (ordy[m]) begin
                m_ov[m] = 0;
            end
            vectors += 4;
            if (ov_w[m] !== m_ov[m]) begin
                miscompares++; $display("FAIL out_valid inst%0d: got %b expected %b", m, ov_w[m], m_ov[m]);
            end
            if (od_w[m] !== m_od[m]) begin
                miscompares++; $display("FAIL out_data inst%0d: got %h expected %h", m, od_w[m], m_od[m]);
            end
            if (ol_w[m] !== m_ol[m]) begin
                miscompares++; $display("FAIL out_last inst%0d: got %b expected %b", m, ol_w[m], m_ol[m]);
            end
            if (os_w[m] !== 2'(m_os[m])) begin
                miscompares++; $display("FAIL out_sel inst%0d: got %0d expected %0d", m, os_w[m], m_os[m]);
            end
        end
    endtask

    // Retire pending beats, closing any open packet, until every instance is empty.
    task automatic drain();
        int guard;
        bit busy;
        guard = 0; busy = 1;
        for (int m = 0; m < NI; m++) ordy[m] = 1'b1;
        while (busy && guard < 100) begin
            step();
            guard++;
            busy = 0;
            for (int m = 0; m < NI; m++) begin
                for (int i = 0; i < N; i++) begin
                    if (hs[m][i]) begin
                        if (m_locked[m] && m_lch[m] == i) begin
                            lst[m][i] = 1'b1; dat[m][i] = $urandom;
                        end else begin
                            vld[m][i] = 1'b0;
                        end
                    end
                end
                if (m_locked[m] && !vld[m][m_lch[m]]) begin
                    vld[m][m_lch[m]] = 1'b1; lst[m][m_lch[m]] = 1'b1; dat[m][m_lch[m]] = $urandom;
                end
                if (vld[m] != '0 || m_locked[m] || m_ov[m]) busy = 1;
            end
        end
        vectors++;
        if (busy) begin
            miscompares++; $display("FAIL drain: still busy after %0d cycles, expected idle", guard);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        set_all(4'b0000, 4'b1111, 1'b1);
        for (int m = 0; m < NI; m++) for (int i = 0; i < N; i++) dat[m][i] = '0;
        #2 rst = 1'b1;
        #1;
        for (int m = 0; m < NI; m++) begin
            vectors += 3;
            if (ov_w[m] !== 1'b0) begin miscompares++; $display("FAIL reset out_valid inst%0d: got %b expected 0", m, ov_w[m]); end
            if (os_w[m] !== 2'd0 || ol_w[m] !== 1'b0) begin
                miscompares++; $display("FAIL reset out_sel/last inst%0d: got %0d/%b expected 0/0", m, os_w[m], ol_w[m]);
            end
            if (od_w[m] !== 32'h0) begin miscompares++; $display("FAIL reset out_data inst%0d: got %h expected 0", m, od_w[m]); end
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic test_rr_stream();
        set_all(4'b1111, 4'b1111, 1'b1);
        for (int m = 0; m < NI; m++) for (int i = 0; i < N; i++) dat[m][i] = 32'hA0 + 32'(i);
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (ov_w[0] !== 1'b1 || od_w[0] !== 32'hA0 + 32'(k % 4) || os_w[0] !== 2'(k % 4)) begin
                miscompares++;
                $display("FAIL rr_stream beat %0d: got v=%b d=%h s=%0d expected v=1 d=%h s=%0d",
                         k, ov_w[0], od_w[0], os_w[0], 32'hA0 + 32'(k % 4), k % 4);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        set_all(4'b0100, 4'b1111, 1'b0);
        for (int m = 0; m < NI; m++) dat[m][2] = 32'h55;
        step();
        for (int m = 0; m < NI; m++) dat[m][2] = 32'h56;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (ov_w[0] !== 1'b1 || od_w[0] !== 32'h55 || rdy_w[0][2] !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure hold %0d: got v=%b d=%h rdy2=%b expected v=1 d=55 rdy2=0",
                         k, ov_w[0], od_w[0], rdy_w[0][2]);
            end
        end
        for (int m = 0; m < NI; m++) ordy[m] = 1'b1;
        step();
        vectors++;
        if (ov_w[0] !== 1'b1 || od_w[0] !== 32'h56) begin
            miscompares++; $display("FAIL backpressure overwrite: got v=%b d=%h expected v=1 d=56", ov_w[0], od_w[0]);
        end
        set_all(4'b0000, 4'b1111, 1'b1);
        step();
        vectors++;
        if (ov_w[0] !== 1'b0) begin
            miscompares++; $display("FAIL backpressure drain: got out_valid %b expected 0", ov_w[0]);
        end
        drain();
    endtask

    task automatic test_fixed_prio();
        set_all(4'b1010, 4'b1111, 1'b1);
        for (int m = 0; m < NI; m++) begin dat[m][1] = 32'h11; dat[m][3] = 32'h33; end
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (os_w[1] !== 2'd1 || od_w[1] !== 32'h11 || rdy_w[1][3] !== 1'b0) begin
                miscompares++;
                $display("FAIL fixed_prio beat %0d: got s=%0d d=%h rdy3=%b expected s=1 d=11 rdy3=0",
                         k, os_w[1], od_w[1], rdy_w[1][3]);
            end
        end
        drain();
    endtask

    task automatic test_pkt_lock();
        int b;
        do_reset();
        set_all(4'b0000, 4'b1111, 1'b1);
        vld[2] = 4'b0011; dat[2][1] = 32'h77; b = 0;
        for (int k = 0; k < 4; k++) begin
            dat[2][0] = 32'h10 + 32'(b);
            lst[2][0] = (b >= 2);
            step();
            vectors++;
            if (os_w[2] !== ((k < 3) ? 2'd0 : 2'd1)) begin
                miscompares++; $display("FAIL pkt_lock beat %0d: got out_sel %0d expected %0d", k, os_w[2], (k < 3) ? 0 : 1);
            end
            if (hs[2][0]) b++;
        end
        drain();
    endtask

    task automatic test_lock_stall();
        set_all(4'b0000, 4'b1111, 1'b1);
        vld[2] = 4'b0100; dat[2][2] = 32'h20; lst[2][2] = 1'b0;
        step();
        vectors++;
        if (os_w[2] !== 2'd2) begin miscompares++; $display("FAIL lock_stall start: got out_sel %0d expected 2", os_w[2]); end
        vld[2] = 4'b0001; dat[2][0] = 32'h30;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (ov_w[2] !== 1'b0 || rdy_w[2][0] !== 1'b0) begin
                miscompares++; $display("FAIL lock_stall gap %0d: got v=%b rdy0=%b expected v=0 rdy0=0", k, ov_w[2], rdy_w[2][0]);
            end
        end
        vld[2] = 4'b0101; dat[2][2] = 32'h21; lst[2][2] = 1'b1;
        step();
        vectors++;
        if (os_w[2] !== 2'd2 || od_w[2] !== 32'h21) begin
            miscompares++; $display("FAIL lock_stall resume: got s=%0d d=%h expected s=2 d=21", os_w[2], od_w[2]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        set_all(4'b0000, 4'b1111, 1'b1);
        vld[2] = 4'b0010; dat[2][1] = 32'h61; lst[2][1] = 1'b0;
        step();
        ordy[2] = 1'b0; dat[2][1] = 32'h62;
        step();
        #3 rst = 1'b1;
        #1;
        for (int m = 0; m < NI; m++) begin
            vectors++;
            if (ov_w[m] !== 1'b0 || os_w[m] !== 2'd0) begin
                miscompares++; $display("FAIL reset_mid inst%0d: got v=%b s=%0d expected v=0 s=0", m, ov_w[m], os_w[m]);
            end
        end
        model_reset();
        set_all(4'b1111, 4'b1111, 1'b1);
        for (int m = 0; m < NI; m++) for (int i = 0; i < N; i++) dat[m][i] = 32'hB0 + 32'(i);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        for (int m = 0; m < NI; m++) begin
            vectors++;
            if (ov_w[m] !== 1'b1 || os_w[m] !== 2'd0) begin
                miscompares++; $display("FAIL reset_mid restart inst%0d: got v=%b s=%0d expected v=1 s=0", m, ov_w[m], os_w[m]);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < NI; m++) begin
                ordy[m] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < N; i++) begin
                    if (!vld[m][i] || hs[m][i]) begin
                        vld[m][i] = 1'($urandom_range(0, 1));
                        dat[m][i] = $urandom;
                        lst[m][i] = ($urandom_range(0, 2) == 0);
                    end
                end
            end
            step();
        end
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rr_stream();
        test_backpressure();
        test_fixed_prio();
        test_pkt_lock();
        test_lock_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
